// File: rtl/pc_unit_if.sv
// rtl/pc_unit_if.sv - Control/fetch bundle for pc_unit (exc/epc present only with PC_EXC_EN)
interface pc_unit_if #(
  parameter int WIDTH = 16
);
  logic             stall;
  logic [2:0]       op;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_udf;
`ifdef PC_EXC_EN
  logic             exc;
  logic [WIDTH-1:0] epc;

  modport master (
    output stall, op, target, offset, exc,
    input  pc, ras_empty, ras_full, ras_ovf, ras_udf, epc
  );
  modport slave (
    input  stall, op, target, offset, exc,
    output pc, ras_empty, ras_full, ras_ovf, ras_udf, epc
  );
`else
  modport master (
    output stall, op, target, offset,
    input  pc, ras_empty, ras_full, ras_ovf, ras_udf
  );
  modport slave (
    input  stall, op, target, offset,
    output pc, ras_empty, ras_full, ras_ovf, ras_udf
  );
`endif
endinterface

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Fetch-stage program counter with circular return-address stack; optional exception entry under PC_EXC_EN
module pc_unit #(
  parameter int               WIDTH      = 16,
  parameter int               STEP       = 1,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int               RAS_DEPTH  = 4,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(16'h0002)
) (
  input logic      clk,
  input logic      reset,
  pc_unit_if.slave bus
);

  localparam int               PW      = $clog2(RAS_DEPTH);
  localparam int               CW      = PW + 1;
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [CW-1:0]    DEPTH_C = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_CALL   = 3'd3;
  localparam logic [2:0] OP_RET    = 3'd4;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  // top_q points at the next free slot; the newest entry sits at top_q-1.
  // When full, top_q also addresses the oldest entry, so a push there
  // naturally overwrites it.
  logic [PW-1:0]    top_q, top_d, top_m1;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_w, empty_w;
  logic             exc_hit;

`ifdef PC_EXC_EN
  logic [WIDTH-1:0] epc_q;
  assign exc_hit = bus.exc;
  assign bus.epc = epc_q;
`else
  assign exc_hit = 1'b0;
`endif

  assign seq_pc  = pc_q + STEP_W;
  assign top_m1  = top_q - PW'(1);
  assign full_w  = (cnt_q == DEPTH_C);
  assign empty_w = (cnt_q == '0);

  assign bus.pc        = pc_q;
  assign bus.ras_empty = empty_w;
  assign bus.ras_full  = full_w;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_udf   = udf_q;

  // Next-PC and stack bookkeeping; exception beats stall, stall beats op.
  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    push  = 1'b0;
    ovf_d = 1'b0;
    udf_d = 1'b0;
    if (exc_hit) begin
      pc_d = EXC_VECTOR;
    end else if (!bus.stall) begin
      case (bus.op)
        OP_BRANCH: pc_d = pc_q + bus.offset;
        OP_JUMP:   pc_d = bus.target;
        OP_CALL: begin
          pc_d  = bus.target;
          push  = 1'b1;
          top_d = top_q + PW'(1);
          if (full_w) ovf_d = 1'b1;
          else        cnt_d = cnt_q + CW'(1);
        end
        OP_RET: begin
          if (!empty_w) begin
            pc_d  = ras_q[top_m1];
            top_d = top_m1;
            cnt_d = cnt_q - CW'(1);
          end else begin
            pc_d  = seq_pc;
            udf_d = 1'b1;
          end
        end
        default:   pc_d = seq_pc;
      endcase
    end
  end

  // PC, stack pointer, occupancy and flag pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      top_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  // Return-address storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (!reset && push) ras_q[top_q] <= seq_pc;
  end

`ifdef PC_EXC_EN
  // Capture the interrupted PC on exception entry.
  always_ff @(posedge clk) begin
    if (reset)        epc_q <= '0;
    else if (exc_hit) epc_q <= pc_q;
  end
`endif

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program counter for the CPU fetch stage. It generalises the plain registered PC with reset, stall, increment, PC-relative branch, absolute jump, and call/return through a circular return-address stack (RAS).
- Sits between the control/decode logic and instruction memory.
- Drives the fetch address every cycle.

Parameters:
- WIDTH, 16, PC and address width in bits.
- STEP, 1, increment applied per sequential instruction (word-addressed memory).
- RESET_PC, 0, PC value loaded on reset.
- RAS_DEPTH, 4, number of return-address stack entries (power of 2, ≥2).
- EXC_VECTOR, 16'h0002, exception target PC (used only with PC_EXC_EN).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold PC and RAS this cycle
- op  input  3  0=INC 1=BRANCH 2=JUMP 3=CALL 4=RET; 5-7 treated as INC
- target  input  WIDTH  absolute destination for JUMP/CALL
- offset  input  WIDTH  two's-complement displacement for BRANCH
- pc  output  WIDTH  current fetch address (registered)
- ras_empty  output  1  RAS holds 0 entries (combinational from count)
- ras_full  output  1  RAS holds RAS_DEPTH entries (combinational from count)
- ras_ovf  output  1  one-cycle pulse: CALL executed while full
- ras_udf  output  1  one-cycle pulse: RET executed while empty
- exc  input  1  exception request (only with PC_EXC_EN)
- epc  output  WIDTH  saved PC of interrupted instruction (only with PC_EXC_EN)

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high; all registers update on posedge clk only.
- Reset values:
  - pc=RESET_PC; RAS count=0, top pointer=0.
  - ras_ovf=0, ras_udf=0, epc=0.
  - RAS entry contents are don't-care.
  - Reset dominates every other input, including mid-call sequences.
- Latency: op/target/offset sampled at edge N; new pc visible after edge N. One-cycle redirect, no bubbles inside this block.
- Priority per cycle: reset > exc (if enabled) > stall > op.
- stall=1: pc, RAS and count hold; ras_ovf/ras_udf forced 0.
- INC: pc <= pc + STEP.
- BRANCH: pc <= pc + offset.
- JUMP: pc <= target.
- CALL:
  - Push pc+STEP; pc <= target; count <= count+1.
  - If full: entry overwrites the oldest (circular top pointer); count stays RAS_DEPTH; ras_ovf=1 for that cycle.
- RET:
  - Not empty: pc <= top entry; pop; count-1.
  - Empty: pc <= pc + STEP; stack unchanged; ras_udf=1 for that cycle.
- Arithmetic: all PC arithmetic is modulo 2^WIDTH. Wrap from all-ones to 0 is legal and silent. Offset is sign-interpreted; no sign extension is needed since widths match.
- CALL immediately followed by RET returns to the CALL's pc+STEP. Back-to-back CALL/RET sequences need no gap cycles.
- ras_ovf and ras_udf are registered pulses and are never both 1.

Optional Feature:
- Macro PC_EXC_EN.
- Defined:
  - exc and epc ports exist.
  - exc=1 (not in reset) loads pc <= EXC_VECTOR and epc <= current pc, even when stall=1.
  - RAS is untouched and op is ignored that cycle.
  - epc otherwise holds.
- Undefined: exc and epc ports are absent; behaviour is identical to exc tied to 0.

Test Plan:
- Reset then 3 cycles of op=INC, STEP=1 -> pc 0,1,2,3. Assert reset with pc=3 -> pc=0 next cycle; ras_empty=1.
- pc=16'h0010, op=BRANCH offset=16'hFFFC -> pc=16'h000C. At pc=16'hFFFF, INC -> pc=16'h0000, no flags.
- pc=5, CALL target=16'h0100 -> pc=16'h0100, ras_empty=0. Next RET -> pc=6, ras_empty=1. Stall during RET cycle holds pc=16'h0100 until released.
- 5 CALLs, RAS_DEPTH=4 -> ras_full after 4th; ras_ovf pulses only on 5th. Then 4 RETs return the 4 newest addresses; 5th RET -> ras_udf=1 and pc+1.
- pc=7 with stall=1 for 3 cycles under any op -> pc stays 7, RAS count unchanged, no flag pulses.
- With PC_EXC_EN: pc=16'h0040, exc=1 with stall=1 and op=CALL -> pc=16'h0002, epc=16'h0040, RAS unchanged.
